// File: rtl/neuron_sched_pkg.sv
// Shared constants and FSM encoding for the layer scheduler that
// time-multiplexes one neuron across the nodes of a layer.
package neuron_sched_pkg;

    localparam int WORD_DATA_BUS = 32;
    localparam int NEU_INPUTS    = 7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_RUN     = 3'd3,
        S_CAPTURE = 3'd4,
        S_CLEAR   = 3'd5,
        S_DONE    = 3'd6
    } sched_state_t;

endpackage

// File: rtl/neuron_sched_timer.sv
// Up-counter with synchronous clear and a terminal-count flag at TERM.
// One instance times RUN, another times the neuron clear window.
module sched_timer
    import neuron_sched_pkg::*;
#(
    parameter int W    = 8,
    parameter int TERM = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] TERM_V = W'(TERM);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == TERM_V);

endmodule

// File: rtl/neuron_sched.sv
// Layer scheduler: per node fetch operands, load the neuron, wait for its
// result (bounded by TIMEOUT), report it, then clear the neuron.
module neuron_sched
    import neuron_sched_pkg::*;
#(
    parameter  int DW      = WORD_DATA_BUS,
    parameter  int NODES   = 4,
    parameter  int TIMEOUT = 31,
    parameter  int CLR_CYC = 2,
    localparam int AW      = (NODES > 1) ? $clog2(NODES) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    output logic                     rd_en,
    output logic [AW-1:0]            rd_addr,
    input  logic [NEU_INPUTS*DW-1:0] rd_data,
    output logic [DW-1:0]            neu_data_0,
    output logic [DW-1:0]            neu_data_1,
    output logic [DW-1:0]            neu_data_2,
    output logic [DW-1:0]            neu_data_3,
    output logic [DW-1:0]            neu_data_4,
    output logic [DW-1:0]            neu_data_5,
    output logic [DW-1:0]            neu_data_6,
    output logic                     neu_in_rdy,
    output logic                     neu_clr_n,
    input  logic [DW-1:0]            neu_out,
    input  logic                     neu_rdy,
    output logic                     res_valid,
    output logic [AW-1:0]            res_idx,
    output logic [DW-1:0]            res_data,
    output logic                     res_err
);

    localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

    sched_state_t  state, state_next;
    logic [AW-1:0] idx;
    logic          armed;
    logic          err_r;
    logic          res_err_r;
    logic [DW-1:0] res_data_r;
    logic [DW-1:0] data_r [NEU_INPUTS];
    logic          run_tc, clr_tc;
    logic          last_node;
    logic          hit, timed_out;

    sched_timer #(.W(8), .TERM(TIMEOUT - 1)) u_run_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state != S_RUN),
        .en    (state == S_RUN),
        .tc    (run_tc)
    );

    sched_timer #(.W(CW), .TERM(CLR_CYC - 1)) u_clr_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state != S_CLEAR),
        .en    (state == S_CLEAR),
        .tc    (clr_tc)
    );

    assign last_node = (idx == AW'(NODES - 1));
    // armed is low only in the first RUN cycle, masking a stale neu_rdy
    assign hit       = armed && neu_rdy;
    assign timed_out = !hit && run_tc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_FETCH;
            S_FETCH:   state_next = S_LOAD;
            S_LOAD:    state_next = S_RUN;
            S_RUN:     if (hit || timed_out) state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_CLEAR;
            S_CLEAR:   if (clr_tc) state_next = last_node ? S_DONE : S_FETCH;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx   <= '0;
            armed <= 1'b0;
            err_r <= 1'b0;
        end else begin
            armed <= (state == S_RUN);
            if (state == S_IDLE && start) begin
                idx   <= '0;
                err_r <= 1'b0;
            end
            if (state == S_CLEAR && clr_tc && !last_node) begin
                idx <= idx + AW'(1);
            end
            if (state == S_RUN && timed_out) begin
                err_r <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_data_r <= '0;
            res_err_r  <= 1'b0;
            for (int j = 0; j < NEU_INPUTS; j++) data_r[j] <= '0;
        end else begin
            if (state == S_LOAD) begin
                for (int j = 0; j < NEU_INPUTS; j++) data_r[j] <= rd_data[j*DW +: DW];
            end
            if (state == S_RUN && hit) begin
                res_data_r <= neu_out;
                res_err_r  <= 1'b0;
            end else if (state == S_RUN && timed_out) begin
                res_data_r <= '0;
                res_err_r  <= 1'b1;
            end
        end
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign err_timeout = err_r;
    assign rd_en       = (state == S_FETCH);
    assign rd_addr     = idx;
    assign neu_in_rdy  = (state == S_RUN) || (state == S_CAPTURE);
    assign neu_clr_n   = (state == S_RUN) || (state == S_CAPTURE);
    assign res_valid   = (state == S_CAPTURE);
    assign res_idx     = idx;
    assign res_data    = res_data_r;
    assign res_err     = res_err_r;
    assign neu_data_0  = data_r[0];
    assign neu_data_1  = data_r[1];
    assign neu_data_2  = data_r[2];
    assign neu_data_3  = data_r[3];
    assign neu_data_4  = data_r[4];
    assign neu_data_5  = data_r[5];
    assign neu_data_6  = data_r[6];

endmodule

// File: doc/neuron_sched.md
# neuron_sched

Layer scheduler that time-multiplexes one `neuron` instance across `NODES` output nodes of a layer. Per node it fetches the 7-word operand bundle from a parameter memory, loads it into the neuron, holds `in_rdy` until `neu_rdy`, captures the result, then clears the neuron before the next node. It sits between the layer-level controller (start/done) and the single neuron datapath.

## Interface

Parameters:
- `DW`, 32: data word width; equals the width of `WordDataBus`.
- `NODES`, 4: nodes per layer pass; range 1..256.
- `TIMEOUT`, 31: maximum number of cycles spent in RUN per node; range 2..255.
- `CLR_CYC`, 2: number of cycles the neuron clear is held low between nodes; minimum 1.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  pulse that begins a layer pass; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted through DONE.
- `done`  out  1  one-cycle pulse at the end of a pass.
- `err_timeout`  out  1  sticky; set on any node timeout, cleared on the next accepted `start`.
- `rd_en`  out  1  parameter-memory read strobe.
- `rd_addr`  out  AW=max(1,clog2(NODES))  node index being fetched.
- `rd_data`  in  7*DW  operand bundle; word j is `rd_data[j*DW +: DW]`; valid exactly 1 cycle after `rd_en`.
- `neu_data_0`..`neu_data_6`  out  DW each  registered operands to the neuron.
- `neu_in_rdy`  out  1  drives the neuron's `in_rdy`.
- `neu_clr_n`  out  1  drives the neuron's `reset` input, which is active-low: high = run, low = clear.
- `neu_out`  in  DW  neuron result.
- `neu_rdy`  in  1  neuron result valid.
- `res_valid`  out  1  one-cycle result strobe.
- `res_idx`  out  AW  node index of the result.
- `res_data`  out  DW  captured `neu_out`; 0 on timeout.
- `res_err`  out  1  high with `res_valid` when the node timed out.

## Operation

States: IDLE, FETCH, LOAD, RUN, CAPTURE, CLEAR, DONE.
- IDLE: `neu_clr_n`=0, `neu_in_rdy`=0. If `start`=1, then `idx`=0, `err_timeout` is cleared, and the next state is FETCH.
- FETCH (1 cycle): `rd_en`=1, `rd_addr`=`idx`. Next state is LOAD.
- LOAD (1 cycle): `rd_data` is registered into `neu_data_0..6`. Next state is RUN, and the timer is cleared.
- RUN: `neu_clr_n`=1, `neu_in_rdy`=1, timer increments every cycle.
  - `neu_rdy` is ignored in the first RUN cycle.
  - If `neu_rdy`=1 from the second RUN cycle on, `neu_out` is latched and the next state is CAPTURE.
  - Otherwise, if the timer reaches `TIMEOUT`-1, the block sets the error flag, forces the result to 0, and goes to CAPTURE.
  - `neu_rdy` takes priority over timeout in the same cycle.
- CAPTURE (1 cycle): `res_valid`=1 with `res_idx`=`idx`, `res_data`, `res_err`. `neu_in_rdy` stays 1 and `neu_clr_n` stays 1. Next state is CLEAR.
- CLEAR (`CLR_CYC` cycles): `neu_clr_n`=0, `neu_in_rdy`=0. On exit:
  - if `idx`==`NODES`-1, next state is DONE;
  - otherwise `idx` increments and the next state is FETCH.
- DONE (1 cycle): `done`=1. Next state is IDLE.
- `neu_data_*` hold their value from LOAD until the next LOAD.

## Timing

- Reset values:
  - state IDLE, `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0;
  - `neu_in_rdy`=0, `neu_clr_n`=0, `neu_data_*`=0;
  - `res_valid`=0, `res_idx`=0, `res_data`=0, `res_err`=0, `err_timeout`=0.
- Per node, where `neu_rdy` is first accepted in RUN cycle k (k≥2): node cycle count = 2 + k + 1 + `CLR_CYC`.
- A timed-out node costs exactly 2 + `TIMEOUT` + 1 + `CLR_CYC` cycles.
- `done` is asserted in the cycle after the last CLEAR cycle. `busy` falls in the cycle after `done`.
- `start` outside IDLE is ignored, including during DONE.
- `reset` during any state returns the block to IDLE on the next edge:
  - outputs take their reset values;
  - a pending `res_valid` is dropped;
  - the neuron is left cleared (`neu_clr_n`=0).
- `NODES`=1: after CLEAR the block goes directly to DONE.

## Structure

- Shared header constants: `NEU_INPUTS`=7, the state encoding, and the `DW` default taken from `WordDataBus`.
- One sub-module: `sched_timer`, the RUN cycle counter. It has clear, enable, and a terminal-count output at `TIMEOUT`-1. It is reused for the CLEAR countdown at `CLR_CYC`-1.

## Test plan

- NODES=4, the neuron model raises `neu_rdy` in RUN cycle 10 with `neu_out`=0x100+idx → `res_valid` ×4 carrying idx 0..3 and data 0x100..0x103, `res_err`=0; `done` is asserted 4×(2+10+1+2)=60 cycles after `start` is accepted.
- `rd_data` words 0x11..0x77 at addr 2 → `neu_data_0..6` equal 0x11..0x77 from the LOAD edge of node 2 until the node-3 LOAD.
- The neuron never asserts `neu_rdy`, TIMEOUT=31 → each node produces `res_err`=1, `res_data`=0; `err_timeout`=1 after node 0 and stays 1 until the next `start`.
- `neu_rdy` is already high in the first RUN cycle, then low → the first cycle is ignored; the node times out (if `neu_rdy` stays low afterwards).
- `reset` asserted in RUN of node 1 → the next cycle shows IDLE, `busy`=0, `neu_clr_n`=0, no `res_valid`; a new `start` restarts from idx 0.
- `start` pulsed while busy and in DONE → ignored; exactly one `done` per accepted `start`.
